qerv_rf_ram_sp_adapter: RTL and testbench
=========================================

// Module: qerv_rf_ram_sp_adapter
// PURPOSE
//  Sits between qerv_rf_ram_if (RAM side: separate read/write strobes) and one single-port SRAM macro.
//  Reads always win the SRAM port; colliding writes go into a small write buffer.
//  The buffer drains in read-free cycles.
//  Buffered data is forwarded to reads so the RF sees dual-port semantics at fixed 1-cycle read latency.
// PARAMETERS
//  width  8  data word width; equals the RF interface width
//  aw     8  word address width
//  DEPTH  4  write-buffer entries; power of 2, >=2
// PORTS
//  i_clk         in   1      clock
//  i_rst         in   1      synchronous, active-high reset
//  i_waddr       in   aw     write address from RF interface
//  i_wdata       in   width  write data
//  i_wen         in   1      write strobe
//  i_raddr       in   aw     read address
//  i_ren         in   1      read strobe
//  o_rdata       out  width  read data, valid the cycle after i_ren
//  o_sram_addr   out  aw     SRAM address
//  o_sram_wdata  out  SW     SRAM write data (SW = width, or width+1 with parity)
//  o_sram_we     out  1      SRAM write enable
//  o_sram_en     out  1      SRAM access enable
//  i_sram_rdata  in   SW     SRAM read data, 1-cycle latency after o_sram_en & !o_sram_we
//  o_full        out  1      write buffer holds DEPTH entries
//  o_ovf         out  1      sticky: a write was dropped
//  o_perr        out  1      parity error pulse, aligned with o_rdata
// BEHAVIOUR
//  Reset: buffer empty; o_rdata=0; o_ovf=0; o_perr=0; o_full=0; o_sram_en=0; o_sram_we=0.
//  Port arbitration, each cycle, highest priority first:
//   1. i_ren: SRAM read at i_raddr.
//   2. Buffer not empty: pop head and write it to SRAM.
//   3. i_wen and buffer empty: write i_waddr/i_wdata directly to SRAM.
//  Push: i_wen is pushed when i_ren=1 or the buffer is non-empty.
//   Pushes and pops in the same cycle are legal; occupancy is then unchanged.
//  Full: a push with no pop while full drops the write and sets o_ovf; o_ovf clears only on reset.
//  Read latency: exactly 1 cycle. o_rdata is registered and holds its last value when there is no read.
//  Forwarding: at an i_ren cycle, a read address match selects the data to return, youngest first:
//   1. A same-cycle i_wen with i_waddr==i_raddr -> i_wdata.
//   2. Otherwise the youngest matching buffer entry.
//   3. Otherwise SRAM data.
//   The forward/SRAM select and forwarded data are registered at the i_ren cycle and applied next cycle.
//  Ordering: buffer is FIFO, so SRAM write order equals arrival order. Same-address writes land in order.
//  Simultaneous i_ren and i_wen to the same address: read returns the new data (write-first).
//  Reset mid-drain: buffered writes are discarded. The RF is re-initialised by software after reset.
//  Occupancy counter is $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
// CONFIGURATION
//  QERV_RF_SP_PARITY_EN defined:
//   SW=width+1; bit [width] of o_sram_wdata = even parity of the data bits.
//   On SRAM-sourced reads, a parity mismatch pulses o_perr for 1 cycle together with o_rdata.
//   Forwarded reads never flag an error.
//  Not defined: SW=width and o_perr is tied 0.
// TESTING
//  1. Reset, then i_wen addr 5 data 0xA5 with no read -> direct SRAM write; buffer stays empty.
//     Read addr 5 -> o_rdata=0xA5 one cycle later.
//  2. Same cycle: i_ren addr 3 and i_wen addr 7 data 0x3C -> read served, write buffered (occupancy 1).
//     Next idle cycle -> SRAM write addr 7 = 0x3C; occupancy 0.
//  3. Buffer addr 9 = 0x11, then read addr 9 before it drains -> o_rdata=0x11 (forwarded).
//     Same-cycle read+write addr 2 data 0x77 -> o_rdata=0x77.
//  4. Hold i_ren=1 and issue 5 writes with DEPTH=4 -> o_full=1 after 4; 5th dropped; o_ovf=1 until reset.
//     Release i_ren -> 4 drains, in order.
//  5. With the macro defined: force i_sram_rdata with a flipped parity bit on a read
//     -> o_perr=1 for 1 cycle; forwarded read of the same address -> o_perr=0.
//  6. Assert i_rst with 3 entries buffered -> occupancy 0, o_ovf=0, no further SRAM writes.

Source files
------------

// File: rtl/qerv_rf_ram_sp_adapter.sv
// Single-port SRAM adapter for the RF: reads own the port, colliding writes queue in a FIFO
// and drain on read-free cycles. Optional SRAM parity bit when QERV_RF_SP_PARITY_EN is defined.
module qerv_rf_ram_sp_adapter #(
  parameter int width = 8,
  parameter int aw    = 8,
  parameter int DEPTH = 4,
`ifdef QERV_RF_SP_PARITY_EN
  localparam int SW   = width + 1
`else
  localparam int SW   = width
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [aw-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic             i_wen,
  input  logic [aw-1:0]    i_raddr,
  input  logic             i_ren,
  output logic [width-1:0] o_rdata,
  output logic [aw-1:0]    o_sram_addr,
  output logic [SW-1:0]    o_sram_wdata,
  output logic             o_sram_we,
  output logic             o_sram_en,
  input  logic [SW-1:0]    i_sram_rdata,
  output logic             o_full,
  output logic             o_ovf,
  output logic             o_perr
);

  localparam int PW = $clog2(DEPTH);

  function automatic logic [SW-1:0] sram_word(input logic [width-1:0] d);
`ifdef QERV_RF_SP_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [aw-1:0]    buf_addr [DEPTH];
  logic [width-1:0] buf_data [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW:0]      cnt;
  logic             ovf;

  logic empty, full, pop, direct, push_req, push, drop;

  always_comb begin
    empty    = (cnt == '0);
    full     = (cnt == (PW+1)'(DEPTH));
    pop      = !i_ren && !empty;
    direct   = !i_ren && empty && i_wen;
    push_req = i_wen && (i_ren || !empty);
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  // SRAM port arbitration: read, then drain, then direct write
  always_comb begin
    o_sram_en    = !i_rst && (i_ren || pop || direct);
    o_sram_we    = !i_rst && !i_ren && (pop || direct);
    o_sram_addr  = i_ren ? i_raddr : (pop ? buf_addr[rd_ptr] : i_waddr);
    o_sram_wdata = sram_word(pop ? buf_data[rd_ptr] : i_wdata);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (drop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= i_waddr;
      buf_data[wr_ptr] <= i_wdata;
    end
  end

  assign o_full = full;
  assign o_ovf  = ovf;

  // Forward select: scan oldest to youngest so the youngest match wins; same-cycle write wins last
  logic             fwd_hit;
  logic [width-1:0] fwd_data;
  logic [PW-1:0]    idx;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = i_wdata;
    idx      = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (((PW+1)'(i) < cnt) && (buf_addr[idx] == i_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_data[idx];
      end
    end
    if (i_wen && (i_waddr == i_raddr)) begin
      fwd_hit  = 1'b1;
      fwd_data = i_wdata;
    end
  end

  // Stage p1: read issued last cycle, SRAM data arriving now
  logic             vld_p1, fwd_p1;
  logic [width-1:0] fwd_data_p1;
  logic [width-1:0] rdata_hold;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1 <= 1'b0;
      fwd_p1 <= 1'b0;
    end else begin
      vld_p1 <= i_ren;
      fwd_p1 <= i_ren && fwd_hit;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_ren) fwd_data_p1 <= fwd_data;
  end

  always_comb begin
    o_rdata = rdata_hold;
    if (vld_p1) o_rdata = fwd_p1 ? fwd_data_p1 : i_sram_rdata[width-1:0];
  end

  // Holds the last returned word between reads
  always_ff @(posedge i_clk) begin
    if (i_rst) rdata_hold <= '0;
    else       rdata_hold <= o_rdata;
  end

`ifdef QERV_RF_SP_PARITY_EN
  assign o_perr = vld_p1 && !fwd_p1 && (^i_sram_rdata);
`else
  assign o_perr = 1'b0;
`endif

endmodule

// File: tb/tb_qerv_rf_ram_sp_adapter.sv
// Scoreboard bench for qerv_rf_ram_sp_adapter: expected reads and SRAM writes are queued at issue
// and compared by a negedge monitor against a behavioural SRAM model.
module tb_qerv_rf_ram_sp_adapter;
`ifdef QERV_RF_SP_PARITY_EN
  localparam int SW = 9;
`else
  localparam int SW = 8;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    waddr = '0, wdata = '0, raddr = '0;
  logic          wen = 1'b0, ren = 1'b0;
  logic [7:0]    rdata;
  logic [7:0]    sram_addr;
  logic [SW-1:0] sram_wdata, sram_rdata;
  logic          sram_we, sram_en, full, ovf, perr;

  qerv_rf_ram_sp_adapter #(.width(8), .aw(8), .DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_waddr(waddr), .i_wdata(wdata), .i_wen(wen),
    .i_raddr(raddr), .i_ren(ren), .o_rdata(rdata), .o_sram_addr(sram_addr),
    .o_sram_wdata(sram_wdata), .o_sram_we(sram_we), .o_sram_en(sram_en),
    .i_sram_rdata(sram_rdata), .o_full(full), .o_ovf(ovf), .o_perr(perr)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM, optional parity-bit corruption on a read
  logic [SW-1:0] mem [256];
  logic          flip_req = 1'b0;
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else sram_rdata <= mem[sram_addr] ^ (flip_req ? (SW'(1) << 8) : SW'(0));
    end
  end

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  logic [8:0]      rd_q [$];
  logic [8+SW-1:0] wr_q [$];

  function automatic logic [SW-1:0] sw_word(input logic [7:0] d);
`ifdef QERV_RF_SP_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  task automatic exp_rd(input logic [7:0] d, input logic p);
    rd_q.push_back({p, d});
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
    wr_q.push_back({a, sw_word(d)});
  endtask

  // Monitor: reads complete one cycle after issue; every SRAM write must match the queue head
  logic rd_pend = 1'b0;
  always @(negedge clk) begin
    logic [8:0]      e;
    logic [8+SW-1:0] w;
    if (rd_pend) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'(rdata), 32'hDEAD);
      else begin
        e = rd_q.pop_front();
        chk("rdata", 32'(rdata), 32'(e[7:0]));
        chk("perr", 32'(perr), 32'(e[8]));
      end
    end
    rd_pend = ren && !rst;
    if (sram_en && sram_we) begin
      if (wr_q.size() == 0) chk("sram_wr_unexpected", 32'({sram_addr, sram_wdata}), 32'hDEAD);
      else begin
        w = wr_q.pop_front();
        chk("sram_wr", 32'({sram_addr, sram_wdata}), 32'(w));
      end
    end
  end

  task automatic step(input logic r, input logic [7:0] ra, input logic w,
                      input logic [7:0] wa, input logic [7:0] wd);
    ren = r; raddr = ra; wen = w; waddr = wa; wdata = wd;
    @(posedge clk); #1;
    ren = 1'b0; wen = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_en", 32'(sram_en), 0);
    chk("rst_we", 32'(sram_we), 0);
    chk("rst_perr", 32'(perr), 0);
    rst = 1'b0;

    // Direct write then read back
    exp_wr(8'd5, 8'hA5);
    step(1'b0, 8'd0, 1'b1, 8'd5, 8'hA5);
    chk("direct_full", 32'(full), 0);
    exp_rd(8'hA5, 1'b0);
    step(1'b1, 8'd5, 1'b0, 8'd0, 8'd0);
    idle(1);

    // Collision: read served, write buffered then drained
    exp_rd(8'h00, 1'b0);
    exp_wr(8'd7, 8'h3C);
    step(1'b1, 8'd3, 1'b1, 8'd7, 8'h3C);
    idle(1);
    exp_rd(8'h3C, 1'b0);
    step(1'b1, 8'd7, 1'b0, 8'd0, 8'd0);

    // Forward from buffer and from a same-cycle write
    exp_rd(8'h00, 1'b0);
    exp_wr(8'd9, 8'h11);
    step(1'b1, 8'd3, 1'b1, 8'd9, 8'h11);
    exp_rd(8'h11, 1'b0);
    step(1'b1, 8'd9, 1'b0, 8'd0, 8'd0);
    exp_rd(8'h77, 1'b0);
    exp_wr(8'd2, 8'h77);
    step(1'b1, 8'd2, 1'b1, 8'd2, 8'h77);
    idle(3);

`ifdef QERV_RF_SP_PARITY_EN
    // Corrupted parity on an SRAM read, then a forwarded read of the same address
    exp_rd(8'hA5, 1'b1);
    flip_req = 1'b1;
    step(1'b1, 8'd5, 1'b0, 8'd0, 8'd0);
    flip_req = 1'b0;
    exp_rd(8'h00, 1'b0);
    exp_wr(8'd5, 8'hA5);
    step(1'b1, 8'd3, 1'b1, 8'd5, 8'hA5);
    exp_rd(8'hA5, 1'b0);
    step(1'b1, 8'd5, 1'b0, 8'd0, 8'd0);
    idle(2);
`endif

    // Fill under continuous reads; fifth write dropped
    for (int i = 0; i < 5; i++) begin
      exp_rd(8'h00, 1'b0);
      if (i < 4) exp_wr(8'(8'd20 + i), 8'(8'h40 + i));
      step(1'b1, 8'd0, 1'b1, 8'(8'd20 + i), 8'(8'h40 + i));
      if (i == 3) begin
        chk("full_after_4", 32'(full), 1);
        chk("ovf_after_4", 32'(ovf), 0);
      end
    end
    chk("full_after_5", 32'(full), 1);
    chk("ovf_after_5", 32'(ovf), 1);
    idle(1);
    chk("full_after_drain1", 32'(full), 0);
    idle(3);
    chk("ovf_sticky", 32'(ovf), 1);
    exp_rd(8'h43, 1'b0);
    step(1'b1, 8'd23, 1'b0, 8'd0, 8'd0);

    // Reset with three entries buffered: all discarded
    for (int i = 0; i < 3; i++) begin
      exp_rd(8'h00, 1'b0);
      step(1'b1, 8'd0, 1'b1, 8'(8'd30 + i), 8'(8'h50 + i));
    end
    rst = 1'b1;
    step(1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
    rst = 1'b0;
    chk("post_rst_full", 32'(full), 0);
    chk("post_rst_ovf", 32'(ovf), 0);
    chk("post_rst_rdata", 32'(rdata), 0);
    idle(4);
    exp_rd(8'h00, 1'b0);
    step(1'b1, 8'd30, 1'b0, 8'd0, 8'd0);
    idle(2);

    chk("rd_q_drained", 32'(rd_q.size()), 0);
    chk("wr_q_drained", 32'(wr_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
